exe_alu_seq: RTL and testbench

EXE_ALU_SEQ -- requirements
Module: exe_alu_seq

---
 rtl/exe_alu_seq.sv | 177 +++++++++++++++++
 tb/tb_exe_alu_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith ops plus a
// shift-and-add unsigned multiplier (MULTU) that takes NB_DATA cycles.
// The result register holds between valid pulses; o_hi holds the upper
// word of the last completed multiply.
module exe_alu_seq #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_FUNC = 6,
    parameter int unsigned NB_CNT  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_FUNC-1:0] i_alu_func,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_flush,
    output logic               o_ready,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_hi,
    output logic               o_zero,
    output logic               o_illegal,
    output logic               o_stall
);

    // Function codes issued by alu_control.
    localparam logic [NB_FUNC-1:0] FuncAdd   = NB_FUNC'(6'b110001);
    localparam logic [NB_FUNC-1:0] FuncSubu  = NB_FUNC'(6'b100011);
    localparam logic [NB_FUNC-1:0] FuncAnd   = NB_FUNC'(6'b100100);
    localparam logic [NB_FUNC-1:0] FuncOr    = NB_FUNC'(6'b100101);
    localparam logic [NB_FUNC-1:0] FuncXor   = NB_FUNC'(6'b100110);
    localparam logic [NB_FUNC-1:0] FuncNor   = NB_FUNC'(6'b100111);
    localparam logic [NB_FUNC-1:0] FuncSlt   = NB_FUNC'(6'b101010);
    localparam logic [NB_FUNC-1:0] FuncLui   = NB_FUNC'(6'b001111);
    localparam logic [NB_FUNC-1:0] FuncMultu = NB_FUNC'(6'b011001);

    localparam int unsigned NbAcc = 2 * NB_DATA;
    localparam logic [NB_CNT-1:0] CntLast = NB_CNT'(NB_DATA - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [NbAcc-1:0]   mcand_q, mcand_d;
    logic [NB_DATA-1:0] mplier_q, mplier_d;
    logic [NbAcc-1:0]   acc_q, acc_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic [NB_DATA-1:0] hi_q, hi_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;

    logic               accept;
    logic               done_ok;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_ill;
    logic               is_mul;
    logic               slt_bit;

    assign accept  = i_valid && (state_q == StIdle) && !i_flush;
    assign slt_bit = ($signed(i_data_a) < $signed(i_data_b));

    // Decode the function code into a single-cycle result or a multiply start.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        case (i_alu_func)
            FuncAdd:   alu_res = i_data_a + i_data_b;
            FuncSubu:  alu_res = i_data_a - i_data_b;
            FuncAnd:   alu_res = i_data_a & i_data_b;
            FuncOr:    alu_res = i_data_a | i_data_b;
            FuncXor:   alu_res = i_data_a ^ i_data_b;
            FuncNor:   alu_res = ~(i_data_a | i_data_b);
            FuncSlt:   alu_res = {{(NB_DATA - 1){1'b0}}, slt_bit};
            FuncLui:   alu_res = i_data_b << 16;
            FuncMultu: is_mul  = 1'b1;
            default:   alu_ill = 1'b1;
        endcase
    end

    // Next-state logic for the FSM and the multiplier datapath.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        hi_d      = hi_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = {{NB_DATA{1'b0}}, i_data_a};
                        mplier_d = i_data_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d  = alu_res;
                        valid_d   = 1'b1;
                        illegal_d = alu_ill;
                    end
                end
            end
            StMul: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + NB_CNT'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                // Commit the product only when the completion was not flushed.
                if (!i_flush) begin
                    result_d = acc_q[NB_DATA-1:0];
                    hi_d     = acc_q[NbAcc-1:NB_DATA];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    // Output mux: DONE presents the product directly so o_hi and o_result move
    // together with o_valid; a same-cycle flush masks the pulse and the update.
    always_comb begin
        done_ok   = (state_q == StDone) && !i_flush;
        o_ready   = (state_q == StIdle);
        o_stall   = !o_ready;
        o_valid   = done_ok || (valid_q && !i_flush);
        o_illegal = illegal_q && !i_flush;
        o_result  = done_ok ? acc_q[NB_DATA-1:0] : result_q;
        o_hi      = done_ok ? acc_q[NbAcc-1:NB_DATA] : hi_q;
        o_zero    = (o_result == '0);
    end

endmodule

// File: tb/tb_exe_alu_seq.sv
// Randomised and directed bench for exe_alu_seq against a behavioural model.
module tb_exe_alu_seq;

    localparam logic [5:0] C_ADD   = 6'b110001;
    localparam logic [5:0] C_SUBU  = 6'b100011;
    localparam logic [5:0] C_AND   = 6'b100100;
    localparam logic [5:0] C_OR    = 6'b100101;
    localparam logic [5:0] C_XOR   = 6'b100110;
    localparam logic [5:0] C_NOR   = 6'b100111;
    localparam logic [5:0] C_SLT   = 6'b101010;
    localparam logic [5:0] C_LUI   = 6'b001111;
    localparam logic [5:0] C_MULTU = 6'b011001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_flush;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic [31:0] o_hi;
    logic        o_zero;
    logic        o_illegal;
    logic        o_stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_res;
    logic [31:0] exp_hi;

    exe_alu_seq #(
        .NB_DATA(32),
        .NB_FUNC(6),
        .NB_CNT (6)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .i_alu_func(func),
        .i_data_a  (a),
        .i_data_b  (b),
        .i_flush   (i_flush),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_hi      (o_hi),
        .o_zero    (o_zero),
        .o_illegal (o_illegal),
        .o_stall   (o_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    function automatic logic known(input logic [5:0] f);
        return f inside {C_ADD, C_SUBU, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_LUI, C_MULTU};
    endfunction

    // Reference behaviour of the single-cycle operations.
    function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ill);
        ill = 1'b0;
        case (f)
            C_ADD:   r = x + y;
            C_SUBU:  r = x - y;
            C_AND:   r = x & y;
            C_OR:    r = x | y;
            C_XOR:   r = x ^ y;
            C_NOR:   r = ~(x | y);
            C_SLT:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            C_LUI:   r = {y[15:0], 16'h0000};
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        i_valid = 1'b1;
        func    = f;
        a       = x;
        b       = y;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; func = '0; a = '0; b = '0;
        #12;
        checks += 7;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", o_ready); end
        if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", o_stall); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
        if (o_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", o_illegal); end
        if (o_result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", o_result); end
        if (o_hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h want 0", o_hi); end
        if (o_zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b want 1", o_zero); end
        exp_hi = 32'd0;
        // Release and present a request in the same cycle: first edge accepts it.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(C_ADD, 32'd3, 32'd4);
        checks += 2;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", o_valid); end
        if (o_result !== 32'd7) begin errors++; $display("FAIL first_result got %h want 7", o_result); end
        tick();
        checks += 2;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL pulse_len got %b want 0", o_valid); end
        if (o_result !== 32'd7) begin errors++; $display("FAIL hold_result got %h want 7", o_result); end
        exp_res = 32'd7;
    endtask

    task automatic test_directed;
        issue(C_SUBU, 32'd5, 32'd5);
        checks += 3;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL subu_valid got %b want 1", o_valid); end
        if (o_result !== 32'd0) begin errors++; $display("FAIL subu_result got %h want 0", o_result); end
        if (o_zero !== 1'b1) begin errors++; $display("FAIL subu_zero got %b want 1", o_zero); end
        issue(C_SLT, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (o_result !== 32'd1) begin errors++; $display("FAIL slt_neg got %h want 1", o_result); end
        issue(C_ADD, 32'hFFFF_FFFF, 32'd1);
        checks += 2;
        if (o_result !== 32'd0) begin errors++; $display("FAIL add_wrap got %h want 0", o_result); end
        if (o_zero !== 1'b1) begin errors++; $display("FAIL add_wrap_zero got %b want 1", o_zero); end
        issue(C_LUI, 32'd0, 32'h1234_ABCD);
        checks++;
        if (o_result !== 32'hABCD_0000) begin errors++; $display("FAIL lui got %h want abcd0000", o_result); end
        issue(6'b111111, 32'h1111_1111, 32'h2222_2222);
        checks += 3;
        if (o_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", o_illegal); end
        if (o_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got %b want 1", o_valid); end
        if (o_result !== 32'd0) begin errors++; $display("FAIL ill_result got %h want 0", o_result); end
        tick();
        checks++;
        if (o_illegal !== 1'b0) begin errors++; $display("FAIL ill_pulse got %b want 0", o_illegal); end
        exp_res = 32'd0;
    endtask

    task automatic test_back_to_back;
        logic [5:0]  f;
        logic [31:0] x, y, r;
        logic        ill, idle;
        logic [5:0]  legal [8] = '{C_ADD, C_SUBU, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_LUI};
        for (int i = 0; i < 300; i++) begin
            idle = ($urandom_range(0, 4) == 0);
            if (idle) begin
                i_valid = 1'b0;
            end else begin
                if ($urandom_range(0, 9) < 8) begin
                    f = legal[$urandom_range(0, 7)];
                end else begin
                    do f = 6'($urandom); while (known(f));
                end
                x = $urandom;
                y = ($urandom_range(0, 3) == 0) ? x : $urandom;
                if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 3));
                model(f, x, y, r, ill);
                i_valid = 1'b1; func = f; a = x; b = y;
            end
            tick();
            checks++;
            if (idle) begin
                if (o_valid !== 1'b0 || o_result !== exp_res) begin
                    errors++;
                    $display("FAIL b2b_hold got v=%b r=%h want v=0 r=%h", o_valid, o_result, exp_res);
                end
            end else begin
                if (o_valid !== 1'b1 || o_result !== r || o_illegal !== ill || o_zero !== (r == 0)) begin
                    errors++;
                    $display("FAIL b2b_op f=%b got v=%b r=%h il=%b z=%b want v=1 r=%h il=%b",
                             f, o_valid, o_result, o_illegal, o_zero, r, ill);
                end
                exp_res = r;
            end
        end
        i_valid = 1'b0;
    endtask

    // Runs one multiply and checks stall, latency and product; optionally holds
    // a second request during the stall, which must be ignored.
    task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input logic hold_req,
                           input string name);
        logic [63:0] p;
        int          lat;
        p = 64'(x) * 64'(y);
        lat = 0;
        issue(C_MULTU, x, y);
        if (hold_req) begin
            i_valid = 1'b1; func = C_ADD; a = 32'd1; b = 32'd1;
        end
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if (o_stall !== 1'b1 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_stall c=%0d got %b want 1", name, c, o_stall);
            end
            if (o_valid === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        i_valid = 1'b0;
        checks += 4;
        if (lat != 33) begin errors++; $display("FAIL %s_latency got %0d want 33", name, lat); end
        if (o_result !== p[31:0]) begin errors++; $display("FAIL %s_lo got %h want %h", name, o_result, p[31:0]); end
        if (o_hi !== p[63:32]) begin errors++; $display("FAIL %s_hi got %h want %h", name, o_hi, p[63:32]); end
        if (o_zero !== (p[31:0] == 0)) begin errors++; $display("FAIL %s_zero got %b", name, o_zero); end
        exp_hi = p[63:32];
        tick();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_hi !== exp_hi) begin
            errors++;
            $display("FAIL %s_after got rdy=%b v=%b hi=%h want rdy=1 v=0 hi=%h", name, o_ready, o_valid, o_hi, exp_hi);
        end
    endtask

    task automatic test_multu;
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, "mul_dir");
        run_mul(32'd0, 32'hDEAD_BEEF, 1'b0, "mul_zero");
        for (int k = 0; k < 4; k++) begin
            run_mul($urandom, $urandom, 1'b0, "mul_rnd");
        end
    endtask

    task automatic test_flush_mul;
        int nv;
        // Flush during MUL cycle 10.
        issue(C_MULTU, $urandom, $urandom);
        nv = 0;
        for (int c = 1; c < 10; c++) begin
            if (o_valid) nv++;
            tick();
        end
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_mul_v got %b want 0", o_valid); end
        tick();
        i_flush = 1'b0;
        #1;
        checks += 3;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL fl_mul_ready got %b want 1", o_ready); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_mul_v2 got %b want 0", o_valid); end
        if (o_hi !== exp_hi) begin errors++; $display("FAIL fl_mul_hi got %h want %h", o_hi, exp_hi); end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_valid) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL fl_mul_novalid got %0d want 0", nv); end
        // Flush in the DONE cycle.
        issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c < 33; c++) tick();
        i_flush = 1'b1;
        #1;
        checks += 2;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_done_v got %b want 0", o_valid); end
        if (o_hi !== exp_hi) begin errors++; $display("FAIL fl_done_hi got %h want %h", o_hi, exp_hi); end
        tick();
        i_flush = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_hi !== exp_hi) begin
            errors++;
            $display("FAIL fl_done_after got rdy=%b v=%b hi=%h want rdy=1 v=0 hi=%h", o_ready, o_valid, o_hi, exp_hi);
        end
    endtask

    task automatic test_flush_idle;
        issue(C_ADD, 32'd1, 32'd2);
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_idle_v got %b want 0", o_valid); end
        tick();
        i_flush = 1'b0;
        issue(6'b111111, 32'd0, 32'd0);
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_illegal !== 1'b0) begin
            errors++;
            $display("FAIL fl_idle_ill got v=%b il=%b want 0 0", o_valid, o_illegal);
        end
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        int nv;
        issue(C_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int c = 1; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %b want 1", o_ready); end
        if (o_stall !== 1'b0) begin errors++; $display("FAIL mr_stall got %b want 0", o_stall); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", o_valid); end
        if (o_illegal !== 1'b0) begin errors++; $display("FAIL mr_illegal got %b want 0", o_illegal); end
        if (o_result !== 32'd0) begin errors++; $display("FAIL mr_result got %h want 0", o_result); end
        if (o_hi !== 32'd0) begin errors++; $display("FAIL mr_hi got %h want 0", o_hi); end
        if (o_zero !== 1'b1) begin errors++; $display("FAIL mr_zero got %b want 1", o_zero); end
        tick();
        tick();
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_valid || !o_ready) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL mr_after got %0d bad cycles want 0", nv); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_multu();
        test_flush_mul();
        test_flush_idle();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
